// File: rtl/irq_ctrl_if.sv
// Bridge-side register window bundle for irq_ctrl: word select, write strobe,
// write data and combinational read data.
interface irq_ctrl_if;
    logic [1:0]  ADD_I;
    logic        WE_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;

    modport master (output ADD_I, output WE_I, output DAT_I, input DAT_O);
    modport slave  (input ADD_I, input WE_I, input DAT_I, output DAT_O);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller feeding the CPU HWInt vector.
// Latches up to NSRC request lines with per-source mask and level/edge mode,
// and exposes MASK / MODE / PEND / ID through a four-word register window.
// Optional build macro: IRQ_CTRL_PRIO_EN -- when defined, HWInt carries only
// the highest-priority (lowest-index) pending unmasked source as a one-hot.
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    irq_ctrl_if.slave       bus,
    input  logic [NSRC-1:0] IRQ_I,
    output logic [5:0]      HWInt
);

    logic [NSRC-1:0] mask_r;
    logic [NSRC-1:0] mode_r;
    logic [NSRC-1:0] pend_r;
    logic [NSRC-1:0] irq_q_r;
    logic [NSRC-1:0] irq_p_r;
    logic [5:0]      hwint_r;

    logic            wr_mask_s;
    logic            wr_mode_s;
    logic            wr_pend_s;
    logic [NSRC-1:0] clr_s;
    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] pend_nxt_s;
    logic [NSRC-1:0] active_s;
    logic [NSRC-1:0] vec_s;
    logic [5:0]      vec_wide_s;
    logic [31:0]     rd_data_s;

    // Isolate the lowest set bit (bit 0 has the highest priority).
    function automatic logic [NSRC-1:0] lowest_onehot(input logic [NSRC-1:0] v);
        return v & (~v + NSRC'(1));
    endfunction

    // Index of the lowest set bit, 0 when nothing is set.
    function automatic logic [2:0] lowest_index(input logic [NSRC-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Decode register writes, detect edges and compute the next pending state.
    always_comb begin
        wr_mask_s  = bus.WE_I && (bus.ADD_I == 2'd0);
        wr_mode_s  = bus.WE_I && (bus.ADD_I == 2'd1);
        wr_pend_s  = bus.WE_I && (bus.ADD_I == 2'd2);
        clr_s      = {NSRC{1'b0}};
        if (wr_pend_s) begin
            clr_s = bus.DAT_I[NSRC-1:0];
        end else begin
            clr_s = {NSRC{1'b0}};
        end
        rise_s     = irq_q_r & ~irq_p_r;
        pend_nxt_s = {NSRC{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            if (mode_r[i]) begin
                // A newly detected edge beats a same-cycle clear.
                pend_nxt_s[i] = rise_s[i] | (pend_r[i] & ~clr_s[i]);
            end else begin
                pend_nxt_s[i] = irq_q_r[i];
            end
        end
    end

    // Build the interrupt vector presented to the CPU.
    always_comb begin
        active_s = pend_r & mask_r;
`ifdef IRQ_CTRL_PRIO_EN
        vec_s = lowest_onehot(active_s);
`else
        vec_s = active_s;
`endif
        vec_wide_s = 6'd0;
        vec_wide_s[NSRC-1:0] = vec_s;
    end

    // Combinational read mux; unused upper bits read as zero.
    always_comb begin
        rd_data_s = 32'd0;
        case (bus.ADD_I)
            2'd0: rd_data_s[NSRC-1:0] = mask_r;
            2'd1: rd_data_s[NSRC-1:0] = mode_r;
            2'd2: rd_data_s[NSRC-1:0] = pend_r;
            2'd3: begin
                rd_data_s[31]  = |active_s;
                rd_data_s[2:0] = lowest_index(active_s);
            end
            default: rd_data_s = 32'd0;
        endcase
    end

    assign bus.DAT_O = rd_data_s;
    assign HWInt     = hwint_r;

    // Register file, request synchronisers, pending latch and output vector.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mask_r  <= {NSRC{1'b0}};
            mode_r  <= {NSRC{1'b0}};
            pend_r  <= {NSRC{1'b0}};
            irq_q_r <= {NSRC{1'b0}};
            irq_p_r <= {NSRC{1'b0}};
            hwint_r <= 6'd0;
        end else begin
            if (wr_mask_s) begin
                mask_r <= bus.DAT_I[NSRC-1:0];
            end else begin
                mask_r <= mask_r;
            end
            if (wr_mode_s) begin
                mode_r <= bus.DAT_I[NSRC-1:0];
            end else begin
                mode_r <= mode_r;
            end
            pend_r  <= pend_nxt_s;
            irq_q_r <= IRQ_I;
            irq_p_r <= irq_q_r;
            hwint_r <= vec_wide_s;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios from the test plan plus
// a randomized run against a cycle-level behavioural model.
module tb_irq_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] irq;
    logic [5:0] hwint;
    int         vectors;
    int         miscompares;

    irq_ctrl_if bus ();

    irq_ctrl #(.NSRC(6)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus),
        .IRQ_I (irq),
        .HWInt (hwint)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [5:0] m_mask, m_mode, m_pend, m_q, m_p, m_hw;

    function automatic logic [5:0] m_vec();
        logic [5:0] a;
        logic [5:0] r;
        a = m_pend & m_mask;
`ifdef IRQ_CTRL_PRIO_EN
        r = 6'd0;
        for (int i = 5; i >= 0; i--)
            if (a[i]) r = 6'd1 << i;
`else
        r = a;
`endif
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [5:0]  act;
        logic [31:0] r;
        act = m_pend & m_mask;
        r = 32'd0;
        case (a)
            2'd0: r[5:0] = m_mask;
            2'd1: r[5:0] = m_mode;
            2'd2: r[5:0] = m_pend;
            default: begin
                for (int i = 5; i >= 0; i--)
                    if (act[i]) r = 32'h8000_0000 | i;
            end
        endcase
        return r;
    endfunction

    // Apply one cycle of inputs, advance one clock edge and update the model.
    task automatic tick(input logic r, input logic we, input logic [1:0] a,
                        input logic [31:0] d, input logic [5:0] iv);
        logic [5:0] clr;
        logic [5:0] pn;
        rst = r; bus.WE_I = we; bus.ADD_I = a; bus.DAT_I = d; irq = iv;
        clr = (we && a == 2'd2) ? d[5:0] : 6'd0;
        @(posedge clk);
        if (r) begin
            m_mask = 6'd0; m_mode = 6'd0; m_pend = 6'd0;
            m_q = 6'd0; m_p = 6'd0; m_hw = 6'd0;
        end else begin
            // level bits copy the sampled line; edge bits latch a fresh rise
            pn = (~m_mode & m_q) | (m_mode & ((m_q & ~m_p) | (m_pend & ~clr)));
            m_hw = m_vec();
            if (we && a == 2'd0) m_mask = d[5:0];
            if (we && a == 2'd1) m_mode = d[5:0];
            m_pend = pn;
            m_p = m_q;
            m_q = iv;
        end
        #1;
        bus.WE_I = 1'b0;
        rst = 1'b0;
    endtask

    task automatic rd_set(input logic [1:0] a);
        bus.ADD_I = a;
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 2'd0, 32'd0, 6'h3F);
        tick(1'b1, 1'b0, 2'd0, 32'd0, 6'h3F);
        vectors++;
        if (hwint !== 6'd0) begin
            miscompares++; $display("FAIL reset_hwint: got %h want 00", hwint);
        end
        for (int a = 0; a < 4; a++) begin
            rd_set(2'(a));
            vectors++;
            if (bus.DAT_O !== 32'd0) begin
                miscompares++; $display("FAIL reset_read[%0d]: got %h want 0", a, bus.DAT_O);
            end
        end
        tick(1'b0, 1'b1, 2'd1, 32'h3F, 6'h3F);
        tick(1'b0, 1'b1, 2'd0, 32'h3F, 6'h3F);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h3F);
        rd_set(2'd2);
        vectors++;
        if (bus.DAT_O !== 32'h3F) begin
            miscompares++; $display("FAIL reset_release_pend: got %h want 3f", bus.DAT_O);
        end
    endtask

    task automatic test_level();
        tick(1'b1, 1'b0, 2'd0, 32'd0, 6'h00);
        tick(1'b0, 1'b1, 2'd0, 32'h3, 6'h00);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h02);   // edge k
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h02);   // k+1
        vectors++;
        if (hwint !== 6'd0) begin
            miscompares++; $display("FAIL level_k1: got %h want 00", hwint);
        end
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h02);   // k+2
        vectors++;
        if (hwint !== 6'h02) begin
            miscompares++; $display("FAIL level_k2: got %h want 02", hwint);
        end
        tick(1'b0, 1'b1, 2'd2, 32'h2, 6'h02);   // W1C on level bit
        rd_set(2'd2);
        vectors++;
        if (bus.DAT_O !== 32'h2 || hwint !== 6'h02) begin
            miscompares++; $display("FAIL level_w1c: got pend %h hw %h want 2/02", bus.DAT_O, hwint);
        end
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);   // edge j
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);   // j+1
        vectors++;
        if (hwint !== 6'h02) begin
            miscompares++; $display("FAIL level_j1: got %h want 02", hwint);
        end
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);   // j+2
        vectors++;
        if (hwint !== 6'd0) begin
            miscompares++; $display("FAIL level_j2: got %h want 00", hwint);
        end
    endtask

    task automatic test_edge();
        tick(1'b1, 1'b0, 2'd0, 32'd0, 6'h00);
        tick(1'b0, 1'b1, 2'd0, 32'h1, 6'h00);
        tick(1'b0, 1'b1, 2'd1, 32'h1, 6'h00);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h01);   // k
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);   // k+2
        for (int n = 0; n < 3; n++) begin
            rd_set(2'd2);
            vectors++;
            if (hwint !== 6'h01 || bus.DAT_O !== 32'h1) begin
                miscompares++; $display("FAIL edge_hold[%0d]: got hw %h pend %h want 01/1", n, hwint, bus.DAT_O);
            end
            tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);
        end
        tick(1'b0, 1'b1, 2'd2, 32'h1, 6'h00);   // w
        rd_set(2'd2);
        vectors++;
        if (bus.DAT_O !== 32'd0 || hwint !== 6'h01) begin
            miscompares++; $display("FAIL edge_clear_w: got pend %h hw %h want 0/01", bus.DAT_O, hwint);
        end
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);   // w+1
        vectors++;
        if (hwint !== 6'd0) begin
            miscompares++; $display("FAIL edge_clear_w1: got %h want 00", hwint);
        end
    endtask

    task automatic test_collision();
        tick(1'b1, 1'b0, 2'd0, 32'd0, 6'h00);
        tick(1'b0, 1'b1, 2'd0, 32'h1, 6'h00);
        tick(1'b0, 1'b1, 2'd1, 32'h1, 6'h00);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h01);   // irq_q rises
        tick(1'b0, 1'b1, 2'd2, 32'h1, 6'h01);   // rise detected + W1C
        rd_set(2'd2);
        vectors++;
        if (bus.DAT_O !== 32'h1) begin
            miscompares++; $display("FAIL collision_set_wins: got %h want 1", bus.DAT_O);
        end
        tick(1'b0, 1'b1, 2'd2, 32'h1, 6'h01);   // plain clear, line still high
        rd_set(2'd2);
        vectors++;
        if (bus.DAT_O !== 32'd0) begin
            miscompares++; $display("FAIL collision_later_clear: got %h want 0", bus.DAT_O);
        end
    endtask

    task automatic test_mask_id();
        logic [5:0] want;
`ifdef IRQ_CTRL_PRIO_EN
        want = 6'b000100;
`else
        want = 6'b010100;
`endif
        tick(1'b1, 1'b0, 2'd0, 32'd0, 6'h00);
        tick(1'b0, 1'b1, 2'd1, 32'h3F, 6'h00);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h14);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);
        rd_set(2'd3);
        vectors++;
        if (hwint !== 6'd0 || bus.DAT_O !== 32'd0) begin
            miscompares++; $display("FAIL masked_id: got hw %h id %h want 00/0", hwint, bus.DAT_O);
        end
        tick(1'b0, 1'b1, 2'd0, 32'h14, 6'h00);
        rd_set(2'd3);
        vectors++;
        if (bus.DAT_O !== 32'h8000_0002) begin
            miscompares++; $display("FAIL id_value: got %h want 80000002", bus.DAT_O);
        end
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);
        vectors++;
        if (hwint !== want) begin
            miscompares++; $display("FAIL unmasked_hwint: got %h want %h", hwint, want);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, 2'd0, 32'd0, 6'h00);
        tick(1'b0, 1'b1, 2'd1, 32'h3F, 6'h00);
        tick(1'b0, 1'b1, 2'd0, 32'h3F, 6'h00);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h05);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);
        tick(1'b0, 1'b0, 2'd0, 32'd0, 6'h00);
        rd_set(2'd2);
        vectors++;
        if (bus.DAT_O !== 32'h5 || hwint === 6'd0) begin
            miscompares++; $display("FAIL mid_setup: got pend %h hw %h want 5/nonzero", bus.DAT_O, hwint);
        end
        tick(1'b1, 1'b0, 2'd0, 32'd0, 6'h00);
        vectors++;
        if (hwint !== 6'd0) begin
            miscompares++; $display("FAIL mid_reset_hwint: got %h want 00", hwint);
        end
        for (int a = 0; a < 4; a++) begin
            rd_set(2'(a));
            vectors++;
            if (bus.DAT_O !== 32'd0) begin
                miscompares++; $display("FAIL mid_reset_read[%0d]: got %h want 0", a, bus.DAT_O);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  iv;
        logic [1:0]  ra;
        logic [31:0] want;
        iv = 6'd0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) iv = 6'($urandom);
            tick($urandom_range(0, 59) == 0, 1'($urandom), 2'($urandom), $urandom, iv);
            vectors++;
            if (hwint !== m_hw) begin
                miscompares++; $display("FAIL rand_hwint[%0d]: got %h want %h", n, hwint, m_hw);
            end
            ra = 2'($urandom);
            rd_set(ra);
            want = exp_rd(ra);
            vectors++;
            if (bus.DAT_O !== want) begin
                miscompares++; $display("FAIL rand_read[%0d] addr %0d: got %h want %h", n, ra, bus.DAT_O, want);
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; irq = 6'd0;
        bus.ADD_I = 2'd0; bus.WE_I = 1'b0; bus.DAT_I = 32'd0;
        vectors = 0; miscompares = 0;
        m_mask = 6'd0; m_mode = 6'd0; m_pend = 6'd0;
        m_q = 6'd0; m_p = 6'd0; m_hw = 6'd0;
        test_reset();
        test_level();
        test_edge();
        test_collision();
        test_mask_id();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller between the bridge-attached devices (timers and later peripherals) and the CPU's `HWInt` input. It latches up to six device request lines, applies per-source masking and level/edge mode, and presents a registered interrupt vector to the CPU. Software reads the highest-priority pending source and clears edge-latched requests through a four-word register window on the bridge.

## Interface

- `NSRC`, 6: number of request sources, 1..6; `HWInt` bits at and above `NSRC` are tied 0.
- `CLK_I` in 1: clock.
- `RST_I` in 1: reset, synchronous, active-high.
- `ADD_I` in 2: word select, driven from `DEV_Addr[3:2]`.
- `WE_I` in 1: write strobe from the bridge.
- `DAT_I` in 32: write data.
- `DAT_O` out 32: read data, combinational from `ADD_I`.
- `IRQ_I` in NSRC: device request lines; bit 0 is highest priority.
- `HWInt` out 6: registered interrupt vector to the CPU.

## Operation

- Registers, reset 0. Bits above `NSRC-1` are written as don't-care and read 0.
  - `ADD_I`=0, MASK RW: bit i=1 enables source i.
  - `ADD_I`=1, MODE RW: bit i=1 selects rising-edge latched; 0 selects level.
  - `ADD_I`=2, PEND: read returns pending bits. Writes are write-1-to-clear, and only edge-mode bits are affected.
  - `ADD_I`=3, ID RO: bit31 = any (PEND & MASK) nonzero; [2:0] = lowest index set in PEND & MASK, else 0. Other bits read 0. Writes are ignored.
- Sampling: `irq_q <= IRQ_I` and `irq_p <= irq_q` every cycle.
- Pending update for bit i:
  - Level mode: `PEND[i] <= irq_q[i]`. A W1C write to this bit has no effect.
  - Edge mode: set when `irq_q[i] & ~irq_p[i]`. Cleared by a W1C write with `DAT_I[i]`=1 at `ADD_I`=2. If set and clear occur in the same cycle, set wins.
- Mode switch from edge to level: PEND[i] follows `irq_q[i]` from the next edge. Switching from level to edge retains the current PEND[i] until it is cleared.
- Output: `HWInt <= vec`. `vec` is PEND & MASK, or the priority-reduced form defined under Configuration.
- Reset (any cycle, including mid-operation):
  - MASK, MODE, PEND, `irq_q`, `irq_p` and `HWInt` all go to 0.
  - An `IRQ_I` held high through reset registers as a rising edge 2 edges after reset deasserts.

## Timing

- Reset values: `HWInt`=0. `DAT_O`=0 for every `ADD_I`.
- Request latency: `IRQ_I` high before edge k gives `irq_q`=1 at k, PEND=1 at k+1 (both modes), and `HWInt`=1 at k+2.
- Deassert latency in level mode: `HWInt` drops at k+2 after `IRQ_I` falls before edge k.
- Register writes take effect at the write edge w:
  - MASK or PEND written at w is reflected in `HWInt` at w+1.
  - MODE written at w governs the PEND update at w+1.
- Reads have zero latency. `DAT_O` reflects register state after the most recent edge.
- The block does not stall; every cycle accepts a write.

## Configuration

- `IRQ_CTRL_PRIO_EN`
  - Defined: `vec` is one-hot, holding only the highest-priority (lowest-index) bit of PEND & MASK, or 0 if none.
  - Undefined: `vec` = PEND & MASK (all pending, unmasked sources visible to the CPU).
  - The ID register behaves identically in both builds.

## Test plan

- Reset: hold `RST_I` 2 cycles with `IRQ_I`=6'h3F -> `HWInt`=0 and reads at `ADD_I` 0..3 return 0. After release, with MODE=0x3F and MASK=0x3F written, PEND=0x3F is observed.
- Level path: MASK=0x3, MODE=0; raise `IRQ_I[1]` before edge k -> `HWInt`=6'b000010 at k+2. Drop it before edge j -> `HWInt`=0 at j+2. A W1C write of 0x2 has no effect while `IRQ_I[1]`=1.
- Edge path: MASK=0x1, MODE=0x1; pulse `IRQ_I[0]` for 1 cycle -> PEND reads 0x1 and `HWInt[0]` stays 1. Write PEND=0x1 at edge w -> PEND=0 at w and `HWInt`=0 at w+1.
- Set/clear collision: edge mode on source 0; issue a W1C of 0x1 in the same cycle the rising edge is detected -> PEND stays 0x1.
- Mask and ID: MODE=0x3F, pulse sources 2 and 4 with MASK=0 -> `HWInt`=0 and ID=0. Write MASK=0x14 -> ID reads 0x80000002. `HWInt` is 6'b000100 with `IRQ_CTRL_PRIO_EN` and 6'b010100 without.
- Reset mid-operation: with PEND=0x5 and `HWInt` nonzero, assert `RST_I` for 1 cycle -> all registers and `HWInt` are 0 at that edge.
